uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
- Transmit serializer for the serial peripheral.
- Drains 9-bit words from the TX FIFO (16x9, registered read port) and shifts them out on a UART line.
- Supports programmable fractional baud, 5-8 data bits, optional parity or 9th bit, and 1 or 2 stop bits.
- Sits between the TX FIFO read port and the tx pin; the AXI register file drives the config inputs.

Parameters:
- BRD_W, 32, width of baud-rate divisor; fixed point 24.8 (integer clocks per bit in [31:8], fraction in [7:0]).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = may start new frames; 0 = finish current frame then idle
- brd  input  BRD_W  clocks per bit, 24.8 fixed point; legal values >= 0x00000200 (2.0)
- data_size  input  2  00=5, 01=6, 10=7, 11=8 data bits
- parity_mode  input  2  00=none, 01=even, 10=odd, 11=send word[8] as extra bit
- two_stop  input  1  1 = two stop bits
- fifo_empty  input  1  TX FIFO empty flag
- fifo_rd_data  input  9  TX FIFO read data; valid the cycle after fifo_rd_request
- fifo_rd_request  output  1  one-cycle pop strobe
- tx  output  1  serial line; idle high
- busy  output  1  high from FETCH through the end of the last stop bit

Behaviour:
- Reset values: tx=1, busy=0, fifo_rd_request=0, state=IDLE, phase accumulator=0, bit counter=0.
- Baud tick:
  - acc += 256 every cycle while not IDLE.
  - When acc+256 >= brd: tick, and acc <= acc+256-brd.
  - Average bit period = brd/256 clocks. Jitter is at most 1 clock.
  - acc is cleared on entering START.
- States: IDLE -> FETCH -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE or FETCH.
- IDLE: if enable && !fifo_empty, assert fifo_rd_request for exactly one cycle and go to FETCH.
- FETCH: wait one cycle for the registered FIFO data.
- LOAD: capture fifo_rd_data into shifter; latch data_size, parity_mode, two_stop for the whole frame; go to START.
- START: tx=0 for one bit period.
- DATA:
  - Shift out LSB first; bit count = data_size+5.
  - Bits above the data size are ignored for parity.
- PARITY (only if parity_mode != 00), one bit:
  - even: XOR of the sent data bits.
  - odd: inverted XOR of the sent data bits.
  - 11: word[8].
- STOP: tx=1 for 1 or 2 bit periods.
  - At the end of STOP: if enable && !fifo_empty, pulse fifo_rd_request and go to FETCH (back-to-back frames, 2-cycle inter-frame gap).
  - Otherwise go to IDLE.
- Config changes mid-frame take effect on the next LOAD. brd is sampled live.
- enable deasserted mid-frame: the current frame completes; no new pop.
- fifo_rd_request is never asserted while fifo_empty=1. At most one pop per frame.
- Reset mid-frame: tx returns to 1 the next cycle. A popped word that was not yet sent is discarded.
- tx is driven from a register, so the line is glitch-free.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined:
  - Extra input port break_req (1 bit).
  - When break_req=1 in IDLE, or at the end of STOP, tx is held 0 and no FIFO pops occur.
  - Release returns tx to 1 and the engine re-enters IDLE.
  - busy=1 during break.
  - A break requested mid-frame waits for the frame to end.
- Undefined: no port; behaviour as above.

Test Plan:
- Single 8N1 frame: brd=0x00000A00, data_size=11, parity_mode=00, FIFO holds 0x055.
  - tx=0 for 10 clk, then 1,0,1,0,1,0,1,0 at 10 clk each, then 1 for 10 clk.
  - fifo_rd_request pulses once; busy ends after 100 clk.
- Parity and size: data_size=00 (5 bits), odd parity, word 0x013.
  - Bits 1,1,0,0,1, parity=0; with two_stop=1, stop high for 20 clk.
- 9th bit: parity_mode=11, word 0x1A5, 8 data bits.
  - Extra bit after data = 1. Word 0x0A5 gives 0.
- Fractional baud and back-to-back: brd=0x00000A80 (10.5), 3 words queued.
  - Bit periods alternate 10/11 clk; total of 20 bit periods = 210 clk ±1.
  - Exactly 3 pops; 2-clk gap between stop end and next start.
- Boundary: enable dropped during DATA of frame 1 with 2 words queued.
  - Frame 1 completes, no second pop, tx=1.
  - Reset asserted mid-DATA: tx=1, busy=0, fifo_rd_request=0 the next cycle.
- UART_TX_BREAK_EN: break_req raised during frame.
  - Frame finishes, then tx=0 while break_req=1, no pops.
  - On release, the next queued word transmits normally.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmit engine: drains 9-bit FIFO words onto a serial line with fractional baud.
// Optional line-break support is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_engine #(
    parameter int BRD_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [BRD_W-1:0] brd,
    input  logic [1:0]       data_size,
    input  logic [1:0]       parity_mode,
    input  logic             two_stop,
    input  logic             fifo_empty,
    input  logic [8:0]       fifo_rd_data,
`ifdef UART_TX_BREAK_EN
    input  logic             break_req,
`endif
    output logic             fifo_rd_request,
    output logic             tx,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state, state_d;
    logic [BRD_W-1:0] acc, acc_d;
    logic [7:0]       shreg, shreg_d;
    logic [2:0]       cnt, cnt_d;
    logic [1:0]       pm_q, pm_d;
    logic             ts_q, ts_d;
    logic             stop_cnt, stop_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;

    logic             brk;
    logic             start_ok;
    logic [BRD_W:0]   acc_sum;
    logic [BRD_W:0]   acc_wrap;
    logic             tick;
    logic [7:0]       mask;
    logic [7:0]       masked;

`ifdef UART_TX_BREAK_EN
    assign brk = break_req;
`else
    assign brk = 1'b0;
`endif

    // A new frame may only be popped when enabled, data waits and reset is not active
    assign start_ok = enable && !fifo_empty && !reset;

    assign acc_sum  = {1'b0, acc} + {{(BRD_W-8){1'b0}}, 9'h100};
    assign acc_wrap = acc_sum - {1'b0, brd};
    assign tick     = (state != S_IDLE) && (acc_sum >= {1'b0, brd});

    // Only the configured number of data bits contribute to parity
    assign mask   = 8'hFF >> (2'd3 - data_size);
    assign masked = fifo_rd_data[7:0] & mask;

    assign tx   = tx_q;
    assign busy = (state != S_IDLE);

    // Next-state, baud accumulator, shifter and line value
    always_comb begin
        state_d         = state;
        acc_d           = acc;
        shreg_d         = shreg;
        cnt_d           = cnt;
        pm_d            = pm_q;
        ts_d            = ts_q;
        stop_d          = stop_cnt;
        par_d           = par_q;
        fifo_rd_request = 1'b0;

        if (state != S_IDLE) begin
            acc_d = tick ? acc_wrap[BRD_W-1:0] : acc_sum[BRD_W-1:0];
        end

        unique case (state)
            S_IDLE: begin
                if (brk) begin
                    state_d = S_BREAK;
                end else if (start_ok) begin
                    fifo_rd_request = 1'b1;
                    state_d         = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shreg_d = fifo_rd_data[7:0];
                cnt_d   = {1'b0, data_size} + 3'd4;
                pm_d    = parity_mode;
                ts_d    = two_stop;
                unique case (parity_mode)
                    2'b01:   par_d = ^masked;
                    2'b10:   par_d = ~^masked;
                    2'b11:   par_d = fifo_rd_data[8];
                    default: par_d = 1'b0;
                endcase
                acc_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (cnt == 3'd0) begin
                        stop_d  = ts_q;
                        state_d = (pm_q != 2'b00) ? S_PARITY : S_STOP;
                    end else begin
                        shreg_d = {1'b0, shreg[7:1]};
                        cnt_d   = cnt - 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    stop_d  = ts_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop_cnt) begin
                        stop_d = 1'b0;
                    end else if (brk) begin
                        state_d = S_BREAK;
                    end else if (start_ok) begin
                        fifo_rd_request = 1'b1;
                        state_d         = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (!brk) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
            S_PARITY: tx_d = par_d;
            S_BREAK:  tx_d = 1'b0;
            default:  tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; tx is registered so the line never glitches
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            acc      <= '0;
            shreg    <= '0;
            cnt      <= '0;
            pm_q     <= 2'b00;
            ts_q     <= 1'b0;
            stop_cnt <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_d;
            acc      <= acc_d;
            shreg    <= shreg_d;
            cnt      <= cnt_d;
            pm_q     <= pm_d;
            ts_q     <= ts_d;
            stop_cnt <= stop_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: cycle-accurate expected trace built from bit-period arithmetic.
// Define UART_TX_BREAK_EN to also exercise the line-break feature.
module tb_uart_tx_engine;

    localparam int MAXC = 8192;
    localparam int BIG  = 1 << 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] brd;
    logic [1:0]  data_size;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic        fifo_empty;
    logic [8:0]  fifo_rd_data;
    logic        fifo_rd_request;
    logic        tx;
    logic        busy;
`ifdef UART_TX_BREAK_EN
    logic        break_req;
`endif

    always #5 clk = ~clk;

    uart_tx_engine #(.BRD_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .brd(brd),
        .data_size(data_size),
        .parity_mode(parity_mode),
        .two_stop(two_stop),
        .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data),
`ifdef UART_TX_BREAK_EN
        .break_req(break_req),
`endif
        .fifo_rd_request(fifo_rd_request),
        .tx(tx),
        .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] fq[$];
    bit         pop_pending;

    bit exp_tx[MAXC];
    bit exp_busy[MAXC];
    bit exp_req[MAXC];
    bit act_tx[MAXC];

    logic [8:0] words[8];
    logic [1:0] cf_size[8];
    logic [1:0] cf_pm[8];
    bit         cf_ts[8];
    int         s_cyc[8];
    int         nw;
    int         horizon;
    int         en_drop;
    int         brk_on;
    int         brk_off;
    int         rst_at;
    int         pops;
    int         busy_cnt;
    int         exp_pops;

    bit fb[16];
    int fb_n;

    task automatic chk(input string nm, input int c, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0d: got %0h, want %0h", nm, c, got, want);
        end
    endtask

    function automatic int cdiv(input int j);
        longint num;
        num = longint'(j) * longint'(brd) + 255;
        return int'(num / 256);
    endfunction

    function automatic bit en_at(input int c);
        return c < en_drop;
    endfunction

    function automatic bit brk_at(input int c);
        return (c >= brk_on) && (c < brk_off);
    endfunction

    // Bits of one frame on the line, in transmit order
    task automatic frame_bits(input int k);
        int nd;
        bit ones;
        nd   = int'(cf_size[k]) + 5;
        fb_n = 0;
        ones = 1'b0;
        fb[fb_n++] = 1'b0;
        for (int i = 0; i < nd; i++) begin
            fb[fb_n++] = words[k][i];
            ones ^= words[k][i];
        end
        case (cf_pm[k])
            2'b01: fb[fb_n++] = ones;
            2'b10: fb[fb_n++] = !ones;
            2'b11: fb[fb_n++] = words[k][8];
            default: ;
        endcase
        fb[fb_n++] = 1'b1;
        if (cf_ts[k]) fb[fb_n++] = 1'b1;
    endtask

    // Bit j of a frame starting at S spans [S+ceil(j*brd/256), S+ceil((j+1)*brd/256))
    task automatic build_model();
        int c, k, r, s, l;
        for (int i = 0; i < MAXC; i++) begin
            exp_tx[i]   = 1'b1;
            exp_busy[i] = 1'b0;
            exp_req[i]  = 1'b0;
        end
        for (int i = 0; i < 8; i++) s_cyc[i] = BIG;
        c = 0;
        k = 0;
        exp_pops = 0;
        while (c < horizon) begin
            if (brk_at(c)) begin
                r = c + 1;
                while (brk_at(r)) r++;
                for (int x = c + 1; x <= r && x < MAXC; x++) begin
                    exp_tx[x]   = 1'b0;
                    exp_busy[x] = 1'b1;
                end
                c = r + 1;
            end else if (en_at(c) && k < nw) begin
                exp_req[c] = 1'b1;
                exp_pops++;
                s = c + 3;
                s_cyc[k] = s;
                frame_bits(k);
                for (int x = c + 1; x < s && x < MAXC; x++) exp_busy[x] = 1'b1;
                for (int j = 0; j < fb_n; j++) begin
                    for (int x = s + cdiv(j); x < s + cdiv(j + 1) && x < MAXC; x++) begin
                        exp_tx[x]   = fb[j];
                        exp_busy[x] = 1'b1;
                    end
                end
                l = s + cdiv(fb_n) - 1;
                k++;
                c = l;
            end else begin
                c++;
            end
        end
    endtask

    task automatic run_scenario(input string tag);
        int f;
        int idx;
        reset = 1'b1;
        enable = 1'b0;
`ifdef UART_TX_BREAK_EN
        break_req = 1'b0;
`endif
        fq.delete();
        fifo_empty = 1'b1;
        fifo_rd_data = 9'h000;
        pop_pending = 1'b0;
        data_size = cf_size[0];
        parity_mode = cf_pm[0];
        two_stop = cf_ts[0];
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({tag, "_rst_tx"}, -1, 32'(tx), 32'd1);
        chk({tag, "_rst_busy"}, -1, 32'(busy), 32'd0);
        chk({tag, "_rst_req"}, -1, 32'(fifo_rd_request), 32'd0);
        horizon = nw * (3 + cdiv(12)) + 30;
        if (brk_off > 0) horizon += brk_off;
        if (horizon > MAXC - 400) horizon = MAXC - 400;
        build_model();
        for (int i = 0; i < nw; i++) fq.push_back(words[i]);
        pops = 0;
        busy_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        fifo_empty = (fq.size() == 0);
        for (int c = 0; c < horizon; c++) begin
            if (pop_pending) begin
                fifo_rd_data = fq.pop_front();
                pop_pending = 1'b0;
            end
            fifo_empty = (fq.size() == 0);
            enable = en_at(c);
`ifdef UART_TX_BREAK_EN
            break_req = brk_at(c);
`endif
            f = 0;
            for (int k = 0; k < nw; k++) if (s_cyc[k] <= c) f = k + 1;
            idx = (f < nw) ? f : nw - 1;
            data_size = cf_size[idx];
            parity_mode = cf_pm[idx];
            two_stop = cf_ts[idx];
            if (rst_at >= 0 && c >= rst_at) reset = 1'b1;
            @(negedge clk);
            act_tx[c] = tx;
            if (busy) busy_cnt++;
            if (rst_at >= 0 && c >= rst_at) begin
                if (c == rst_at + 1) begin
                    chk({tag, "_midrst_tx"}, c, 32'(tx), 32'd1);
                    chk({tag, "_midrst_busy"}, c, 32'(busy), 32'd0);
                    chk({tag, "_midrst_req"}, c, 32'(fifo_rd_request), 32'd0);
                end
            end else begin
                chk({tag, "_tx"}, c, 32'(tx), 32'(exp_tx[c]));
                chk({tag, "_busy"}, c, 32'(busy), 32'(exp_busy[c]));
                chk({tag, "_req"}, c, 32'(fifo_rd_request), 32'(exp_req[c]));
            end
            if (fifo_rd_request) begin
                pops++;
                if (fq.size() > 0) pop_pending = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic uni_cfg(input logic [1:0] sz, input logic [1:0] pm, input bit ts);
        for (int i = 0; i < 8; i++) begin
            cf_size[i] = sz;
            cf_pm[i] = pm;
            cf_ts[i] = ts;
        end
        en_drop = BIG;
        brk_on = 0;
        brk_off = 0;
        rst_at = -1;
    endtask

    task automatic chk_bits(input string nm, input int base, input logic [15:0] v,
                            input int n);
        for (int i = 0; i < n; i++) begin
            chk(nm, i, 32'(act_tx[base + 10 * i + 5]), 32'(v[i]));
        end
    endtask

    initial begin
        int hi;
        reset = 1'b1;
        enable = 1'b0;
        brd = 32'h0000_0A00;
        data_size = 2'b11;
        parity_mode = 2'b00;
        two_stop = 1'b0;
        fifo_empty = 1'b1;
        fifo_rd_data = 9'h000;
`ifdef UART_TX_BREAK_EN
        break_req = 1'b0;
`endif

        uni_cfg(2'b11, 2'b00, 1'b0);
        brd = 32'h0000_0A00;
        nw = 1;
        words[0] = 9'h055;
        run_scenario("8n1");
        chk("8n1_pops", 0, pops, 1);
        chk("8n1_busy_cycles", 0, busy_cnt, 102);
        chk_bits("8n1_bit", 3, 16'h02AA, 10);

        uni_cfg(2'b00, 2'b10, 1'b1);
        nw = 1;
        words[0] = 9'h013;
        run_scenario("5o2");
        chk_bits("5o2_bit", 3, 16'h01A6, 9);
        hi = 0;
        for (int x = 73; x < 93; x++) hi += int'(act_tx[x]);
        chk("5o2_stop_high", 0, hi, 20);
        chk("5o2_busy_cycles", 0, busy_cnt, 92);

        uni_cfg(2'b11, 2'b11, 1'b0);
        nw = 2;
        words[0] = 9'h1A5;
        words[1] = 9'h0A5;
        run_scenario("bit9");
        chk("bit9_extra_1", 0, 32'(act_tx[3 + 95]), 32'd1);
        chk("bit9_extra_0", 0, 32'(act_tx[115 + 95]), 32'd0);

        uni_cfg(2'b11, 2'b00, 1'b0);
        brd = 32'h0000_0A80;
        nw = 3;
        words[0] = 9'h0F0;
        words[1] = 9'h00F;
        words[2] = 9'h1AA;
        run_scenario("frac");
        chk("frac_pops", 0, pops, 3);
        chk("frac_gap_hi", 0, 32'(act_tx[109]), 32'd1);
        chk("frac_start2", 0, 32'(act_tx[110]), 32'd0);
        chk("frac_gap3_hi", 0, 32'(act_tx[216]), 32'd1);
        chk("frac_start3", 0, 32'(act_tx[217]), 32'd0);
        chk("frac_busy_cycles", 0, busy_cnt, 321);

        uni_cfg(2'b11, 2'b00, 1'b0);
        brd = 32'h0000_0A00;
        nw = 2;
        words[0] = 9'h0C3;
        words[1] = 9'h03C;
        en_drop = 28;
        run_scenario("endrop");
        chk("endrop_pops", 0, pops, 1);
        chk("endrop_busy_cycles", 0, busy_cnt, 102);
        chk("endrop_tx_end", 0, 32'(act_tx[horizon - 1]), 32'd1);

        uni_cfg(2'b11, 2'b00, 1'b0);
        nw = 2;
        words[0] = 9'h0C3;
        words[1] = 9'h03C;
        rst_at = 28;
        run_scenario("rst");

`ifdef UART_TX_BREAK_EN
        uni_cfg(2'b11, 2'b00, 1'b0);
        nw = 2;
        words[0] = 9'h055;
        words[1] = 9'h0AA;
        brk_on = 20;
        brk_off = 150;
        run_scenario("brk");
        chk("brk_pops", 0, pops, 2);
        chk("brk_low_mid", 0, 32'(act_tx[120]), 32'd0);
        chk("brk_low_last", 0, 32'(act_tx[150]), 32'd0);
        chk("brk_release", 0, 32'(act_tx[151]), 32'd1);
        chk("brk_next_start", 0, 32'(act_tx[154]), 32'd0);
        chk("brk_next_d0", 0, 32'(act_tx[169]), 32'd0);
        chk("brk_next_d1", 0, 32'(act_tx[179]), 32'd1);
`endif

        for (int t = 0; t < 30; t++) begin
            uni_cfg(2'b11, 2'b00, 1'b0);
            nw = int'($urandom_range(1, 4));
            brd = $urandom_range(32'h200, 32'h1000);
            for (int i = 0; i < 8; i++) begin
                words[i] = 9'($urandom);
                cf_size[i] = 2'($urandom);
                cf_pm[i] = 2'($urandom);
                cf_ts[i] = 1'($urandom);
            end
            if ($urandom_range(0, 3) == 0) en_drop = int'($urandom_range(1, 300));
`ifdef UART_TX_BREAK_EN
            if ($urandom_range(0, 2) == 0) begin
                brk_on = int'($urandom_range(0, 300));
                brk_off = brk_on + int'($urandom_range(1, 60));
            end
`endif
            run_scenario("rand");
            chk("rand_pops", t, pops, exp_pops);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
